// File: rtl/writeback_unit_pkg.sv
// Shared constants, load-tag format and load alignment helper for the writeback stage.
package writeback_unit_pkg;
  localparam int NUM_REG_DEF        = 32;
  localparam int REG_ADDR_WIDTH_DEF = 5;
  localparam int REG_WIDTH_DEF      = 32;
  localparam int LD_DEPTH_DEF       = 4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [2:0] f3;
    logic [1:0] off;
  } ld_fmt_t;

  // Returns {encoding_error, aligned_word}; unknown funct3 falls back to a full word.
  function automatic logic [32:0] align_load(ld_fmt_t fmt, logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {fmt.off, 3'b000});
    h = fmt.off[1] ? word[31:16] : word[15:0];
    case (fmt.f3)
      F3_LB:   return {1'b0, {{24{b[7]}}, b}};
      F3_LBU:  return {1'b0, 24'h0, b};
      F3_LH:   return {1'b0, {{16{h[15]}}, h}};
      F3_LHU:  return {1'b0, 16'h0, h};
      F3_LW:   return {1'b0, word};
      default: return {1'b1, word};
    endcase
  endfunction
endpackage

// File: rtl/writeback_unit_ld_tag_fifo.sv
// In-order tag FIFO for outstanding loads; every slot is exposed so the
// owner can build a per-register pending mask.
module ld_tag_fifo
  import writeback_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RD_W  = 5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [RD_W-1:0]             push_rd,
  input  ld_fmt_t                     push_fmt,
  input  logic                        pop,
  output logic                        full,
  output logic                        empty,
  output logic [RD_W-1:0]             head_rd,
  output ld_fmt_t                     head_fmt,
  output logic [DEPTH-1:0][RD_W-1:0]  ent_rd,
  output logic [DEPTH-1:0]            ent_vld
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0]           vld_q, vld_d;
  logic [DEPTH-1:0][RD_W-1:0] rd_q, rd_d;
  ld_fmt_t [DEPTH-1:0]        fmt_q, fmt_d;

  // Caller only pushes when not full, so the write slot never aliases a popped slot.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    vld_d    = vld_q;
    rd_d     = rd_q;
    fmt_d    = fmt_q;
    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = rd_ptr_q + 1'b1;
    end
    if (push) begin
      vld_d[wr_ptr_q] = 1'b1;
      rd_d[wr_ptr_q]  = push_rd;
      fmt_d[wr_ptr_q] = push_fmt;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      vld_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      vld_q    <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    rd_q  <= rd_d;
    fmt_q <= fmt_d;
  end

  assign full     = &vld_q;
  assign empty    = ~|vld_q;
  assign head_rd  = rd_q[rd_ptr_q];
  assign head_fmt = fmt_q[rd_ptr_q];
  assign ent_rd   = rd_q;
  assign ent_vld  = vld_q;
endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: merges ALU results and in-order load responses onto the
// single register-file write port, with load alignment and pending tracking.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int NUM_REG        = NUM_REG_DEF,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int REG_WIDTH      = REG_WIDTH_DEF,
  parameter int LD_DEPTH       = LD_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alu_valid,
  output logic                      alu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
  input  logic [REG_WIDTH-1:0]      alu_data,
  input  logic                      ld_req_valid,
  output logic                      ld_req_ready,
  input  logic [REG_ADDR_WIDTH-1:0] ld_req_rd,
  input  logic [2:0]                ld_req_f3,
  input  logic [1:0]                ld_req_off,
  input  logic                      ld_rsp_valid,
  input  logic [REG_WIDTH-1:0]      ld_rsp_data,
  output logic                      wr_en,
  output logic [REG_ADDR_WIDTH-1:0] addr_rd,
  output logic [REG_WIDTH-1:0]      data_rd,
  output logic [NUM_REG-1:0]        rd_pending,
  output logic                      ld_err
);
  logic                                   full, empty, push, pop;
  logic [REG_ADDR_WIDTH-1:0]              head_rd;
  ld_fmt_t                                head_fmt;
  logic [LD_DEPTH-1:0][REG_ADDR_WIDTH-1:0] ent_rd;
  logic [LD_DEPTH-1:0]                    ent_vld;
  logic [32:0]                            aligned;

  logic                      wr_en_q, wr_en_d, ld_err_q, ld_err_d;
  logic [REG_ADDR_WIDTH-1:0] addr_rd_q, addr_rd_d;
  logic [REG_WIDTH-1:0]      data_rd_q, data_rd_d;

  assign alu_ready    = ~ld_rsp_valid;
  assign ld_req_ready = ~full;
  assign push         = ld_req_valid & ~full;
  assign pop          = ld_rsp_valid & ~empty;

  ld_tag_fifo #(.DEPTH(LD_DEPTH), .RD_W(REG_ADDR_WIDTH)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_rd  (ld_req_rd),
    .push_fmt ({ld_req_f3, ld_req_off}),
    .pop      (pop),
    .full     (full),
    .empty    (empty),
    .head_rd  (head_rd),
    .head_fmt (head_fmt),
    .ent_rd   (ent_rd),
    .ent_vld  (ent_vld)
  );

  assign aligned = align_load(head_fmt, 32'(ld_rsp_data));

  // Repeated destinations in the queue simply OR together; x0 is never pending.
  always_comb begin
    rd_pending = '0;
    for (int i = 0; i < LD_DEPTH; i++)
      if (ent_vld[i]) rd_pending[ent_rd[i]] = 1'b1;
    rd_pending[0] = 1'b0;
  end

  always_comb begin
    wr_en_d   = 1'b0;
    addr_rd_d = addr_rd_q;
    data_rd_d = data_rd_q;
    ld_err_d  = ld_err_q;
    if (ld_rsp_valid) begin
      if (empty) begin
        ld_err_d = 1'b1;
      end else begin
        if (aligned[32]) ld_err_d = 1'b1;
        if (head_rd != '0) begin
          wr_en_d   = 1'b1;
          addr_rd_d = head_rd;
          data_rd_d = REG_WIDTH'(aligned[31:0]);
        end
      end
    end else if (alu_valid && alu_rd != '0) begin
      wr_en_d   = 1'b1;
      addr_rd_d = alu_rd;
      data_rd_d = alu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q   <= 1'b0;
      addr_rd_q <= '0;
      data_rd_q <= '0;
      ld_err_q  <= 1'b0;
    end else begin
      wr_en_q   <= wr_en_d;
      addr_rd_q <= addr_rd_d;
      data_rd_q <= data_rd_d;
      ld_err_q  <= ld_err_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign addr_rd = addr_rd_q;
  assign data_rd = data_rd_q;
  assign ld_err  = ld_err_q;
endmodule
